// File: rtl/mem_cycle_seq.sv
// mem_cycle_seq: arbitrates two byte/word requesters onto a single byte-wide
// memory cycle unit and splits 16-bit transfers into two little-endian byte cycles.
// Latency: ready in the accept cycle, cyc_activate one cycle later, done two cycles after cyc_done.
// Backpressure: requests are taken only in IDLE; a pending valid sees ready=0 until the sequencer is idle.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   reqN_valid/wr/word/addr/wdata  requester N transfer request (N = 0, 1)
//   reqN_ready, reqN_done      one-cycle accept and completion pulses
//   reqN_rdata                 read result, updated in the done cycle and held afterwards
//   cyc_activate/addr/rd/wr/wdata  byte cycle request to the memory cycle unit
//   cyc_rdata, cyc_done        byte read data and completion pulse from the cycle unit
//   busy                       high whenever the sequencer is not idle
//
// Build option: define MEM_CYCLE_SEQ_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise requester 0 has fixed priority.
module mem_cycle_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic        req0_word,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic        req1_word,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [15:0] req1_rdata,
  output logic        cyc_activate,
  output logic [15:0] cyc_addr,
  output logic        cyc_rd,
  output logic        cyc_wr,
  output logic [7:0]  cyc_wdata,
  input  logic [7:0]  cyc_rdata,
  input  logic        cyc_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t      state;

  // Transfer context captured at accept; requester inputs are ignored afterwards.
  logic        l_id;
  logic        l_wr;
  logic        l_word;
  logic [15:0] l_addr;
  logic [15:0] l_wdata;
  logic        idx;
  logic [15:0] res;

  logic        gnt0;
  logic        gnt1;

`ifdef MEM_CYCLE_SEQ_RR_EN
  // 1 = requester 1 was granted last; on contention the other requester wins.
  logic        last_gnt;

  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_gnt);
    gnt1 = req1_valid && (!req0_valid || !last_gnt);
  end
`else
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid && !req0_valid;
  end
`endif

  // Ready is the same-cycle handshake; gating with reset keeps it low while
  // reset is held so no request slips in before the first clean edge.
  assign req0_ready = (state == S_IDLE) && !reset && gnt0;
  assign req1_ready = (state == S_IDLE) && !reset && gnt1;
  assign busy       = (state != S_IDLE);

  // Selected requester's fields, used only on the accept edge.
  logic        sel_wr;
  logic        sel_word;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  always_comb begin
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_word  = gnt1 ? req1_word  : req0_word;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  end

  // Result with the current byte merged in; this is what gets published when
  // the last byte is captured, so rdata is valid in the same cycle as done.
  logic [15:0] capt_res;

  always_comb begin
    capt_res = res;
    if (!l_wr) begin
      if (idx) capt_res[15:8] = cyc_rdata;
      else     capt_res[7:0]  = cyc_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      l_id         <= 1'b0;
      l_wr         <= 1'b0;
      l_word       <= 1'b0;
      l_addr       <= 16'h0000;
      l_wdata      <= 16'h0000;
      idx          <= 1'b0;
      res          <= 16'h0000;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_rdata   <= 16'h0000;
      req1_rdata   <= 16'h0000;
      cyc_activate <= 1'b0;
      cyc_addr     <= 16'h0000;
      cyc_rd       <= 1'b0;
      cyc_wr       <= 1'b0;
      cyc_wdata    <= 8'h00;
`ifdef MEM_CYCLE_SEQ_RR_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            l_id         <= gnt1;
            l_wr         <= sel_wr;
            l_word       <= sel_word;
            l_addr       <= sel_addr;
            l_wdata      <= sel_wdata;
            idx          <= 1'b0;
            res          <= 16'h0000;
            // Cycle outputs are loaded here so they are already stable in ISSUE.
            cyc_activate <= 1'b1;
            cyc_addr     <= sel_addr;
            cyc_rd       <= !sel_wr;
            cyc_wr       <= sel_wr;
            cyc_wdata    <= sel_wdata[7:0];
`ifdef MEM_CYCLE_SEQ_RR_EN
            last_gnt     <= gnt1;
`endif
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cyc_activate <= 1'b0;
          state        <= S_WAIT;
        end

        S_WAIT: begin
          if (cyc_done) state <= S_CAPT;
        end

        S_CAPT: begin
          res <= capt_res;
          if (l_word && !idx) begin
            // High byte lives at addr+1; the 16-bit add wraps FFFF -> 0000.
            idx          <= 1'b1;
            cyc_activate <= 1'b1;
            cyc_addr     <= l_addr + 16'd1;
            cyc_wdata    <= l_wdata[15:8];
            state        <= S_ISSUE;
          end else begin
            cyc_addr  <= 16'h0000;
            cyc_rd    <= 1'b0;
            cyc_wr    <= 1'b0;
            cyc_wdata <= 8'h00;
            if (l_id) begin
              req1_done  <= 1'b1;
              req1_rdata <= capt_res;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= capt_res;
            end
            state <= S_DONE;
          end
        end

        S_DONE: begin
          req0_done <= 1'b0;
          req1_done <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_seq.sv
// Scoreboard bench for mem_cycle_seq: directed transfers push expected byte
// cycles and completions into queues; a negedge monitor pops and compares.
// A behavioural cycle unit answers each cyc_activate after a set delay.
module tb_mem_cycle_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_wr, req0_word;
  logic [15:0] req0_addr, req0_wdata;
  logic        req0_ready, req0_done;
  logic [15:0] req0_rdata;
  logic        req1_valid, req1_wr, req1_word;
  logic [15:0] req1_addr, req1_wdata;
  logic        req1_ready, req1_done;
  logic [15:0] req1_rdata;
  logic        cyc_activate, cyc_rd, cyc_wr;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic [7:0]  cyc_rdata;
  logic        cyc_done;
  logic        busy;

  logic        unit_done;
  logic        spur_done;
  assign cyc_done = unit_done | spur_done;

  always #5 clk = ~clk;

  mem_cycle_seq dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_word(req0_word),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_word(req1_word),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .cyc_activate(cyc_activate), .cyc_addr(cyc_addr), .cyc_rd(cyc_rd),
    .cyc_wr(cyc_wr), .cyc_wdata(cyc_wdata), .cyc_rdata(cyc_rdata),
    .cyc_done(cyc_done), .busy(busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  wdata;
  } cyc_exp_t;

  typedef struct {
    int          id;
    logic        chk;
    logic [15:0] rdata;
  } done_exp_t;

  cyc_exp_t   cq[$];
  done_exp_t  dq[$];
  logic [7:0] rbytes[$];
  int         unit_delay = 3;
  int         total = 0;
  int         bad = 0;
  int         cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cyc(input logic [15:0] addr, input logic rd, input logic [7:0] wdata);
    cyc_exp_t e;
    e.addr = addr; e.rd = rd; e.wdata = wdata;
    cq.push_back(e);
  endtask

  task automatic push_done(input int id, input logic chk, input logic [15:0] rdata);
    done_exp_t e;
    e.id = id; e.chk = chk; e.rdata = rdata;
    dq.push_back(e);
  endtask

  // Behavioural memory cycle unit.
  initial begin : unit
    logic u_rd;
    unit_done = 1'b0;
    cyc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (cyc_activate && !reset) begin
        u_rd = cyc_rd;
        repeat (unit_delay) @(posedge clk);
        #1;
        unit_done = 1'b1;
        if (u_rd && rbytes.size() > 0) cyc_rdata = rbytes.pop_front();
        @(posedge clk);
        #1;
        unit_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  int       acc_cyc = 0;
  int       last_cdone = 0;
  logic     first_act = 1'b0;
  cyc_exp_t cur;

  always @(negedge clk) begin : mon
    cyc_exp_t  ce;
    done_exp_t de;
    int        did;
    if (!reset) begin
      if (req0_ready && req1_ready) check("ready_onehot", 64'd1, 64'd0);
      if (req0_ready || req1_ready) begin
        acc_cyc   = cyc_n;
        first_act = 1'b1;
      end
      if (cyc_activate) begin
        if (cq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_activate: addr %h", cyc_addr);
        end else begin
          ce = cq.pop_front();
          check("cyc_addr", 64'(cyc_addr), 64'(ce.addr));
          check("cyc_rd_wr", {62'd0, cyc_rd, cyc_wr}, {62'd0, ce.rd, !ce.rd});
          check("cyc_wdata", 64'(cyc_wdata), 64'(ce.wdata));
          cur = ce;
        end
        if (first_act) check("act_latency", 64'(cyc_n), 64'(acc_cyc + 1));
        first_act = 1'b0;
      end
      if (cyc_done && busy) begin
        check("cyc_stable", {39'd0, cyc_addr, cyc_rd, cyc_wdata},
              {39'd0, cur.addr, cur.rd, cur.wdata});
        last_cdone = cyc_n;
      end
      if (req0_done || req1_done) begin
        check("done_onehot", {63'd0, req0_done && req1_done}, 64'd0);
        did = req1_done ? 1 : 0;
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: id %0d", did);
        end else begin
          de = dq.pop_front();
          check("done_id", 64'(did), 64'(de.id));
          if (de.chk)
            check("rdata", 64'(did ? req1_rdata : req0_rdata), 64'(de.rdata));
        end
        check("done_latency", 64'(cyc_n), 64'(last_cdone + 2));
      end
      if (!busy || req0_done || req1_done)
        check("cyc_idle_zero", {37'd0, cyc_activate, cyc_rd, cyc_wr, cyc_addr, cyc_wdata}, 64'd0);
    end
  end

  task automatic do_accept(input int id, input logic wr, input logic word,
                           input logic [15:0] addr, input logic [15:0] wdata);
    int   n;
    logic got;
    @(posedge clk); #1;
    if (id == 0) begin
      req0_wr = wr; req0_word = word; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_wr = wr; req1_word = word; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
    n = 0; got = 1'b0;
    while (n < 50 && !got) begin
      @(negedge clk);
      n++;
      got = (id == 0) ? req0_ready : req1_ready;
    end
    check("accept", {63'd0, got}, 64'd1);
    // Drop valid and scramble the request so only the latched copy can be used.
    @(posedge clk); #1;
    if (id == 0) begin
      req0_valid = 1'b0; req0_wr = ~wr; req0_word = ~word; req0_addr = 16'hDEAD; req0_wdata = 16'hBEEF;
    end else begin
      req1_valid = 1'b0; req1_wr = ~wr; req1_word = ~word; req1_addr = 16'hDEAD; req1_wdata = 16'hBEEF;
    end
  endtask

  task automatic wait_done();
    int   n;
    logic seen;
    n = 0; seen = 1'b0;
    while (n < 300 && !seen) begin
      @(negedge clk);
      n++;
      if (req0_done || req1_done) seen = 1'b1;
      else check("busy_in_xfer", {63'd0, busy}, 64'd1);
    end
    check("done_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 400 && dq.size() > 0) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(dq.size()), 64'd0);
  endtask

  initial begin : stim
    int ids[4];
    int cnt;
    int n;
    reset = 1'b1;
    spur_done = 1'b0;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_word = 1'b0; req0_addr = 16'h1234; req0_wdata = 16'h0000;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_word = 1'b0; req1_addr = 16'h0000; req1_wdata = 16'h0000;

    // Reset state, with a valid request held to confirm nothing is accepted.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req0_ready, req0_done, req0_rdata, req1_ready, req1_done, req1_rdata,
           cyc_activate, cyc_addr, cyc_rd, cyc_wr, cyc_wdata, busy}, 64'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    // Byte read, unit answers after 3 cycles.
    unit_delay = 3;
    rbytes.push_back(8'hFE);
    push_cyc(16'h1234, 1'b1, 8'h00);
    push_done(0, 1'b1, 16'h00FE);
    do_accept(0, 1'b0, 1'b0, 16'h1234, 16'h0000);
    wait_done();
    repeat (3) @(negedge clk);
    check("rdata_hold0", 64'(req0_rdata), 64'h00FE);

    // Word write across the address wrap.
    unit_delay = 2;
    push_cyc(16'hFFFF, 1'b0, 8'h67);
    push_cyc(16'h0000, 1'b0, 8'hAB);
    push_done(1, 1'b0, 16'h0000);
    do_accept(1, 1'b1, 1'b1, 16'hFFFF, 16'hAB67);
    wait_done();
    repeat (2) @(negedge clk);
    check("rdata_hold_other", 64'(req0_rdata), 64'h00FE);

    // Word read with 6-cycle wait states per byte.
    unit_delay = 6;
    rbytes.push_back(8'h34);
    rbytes.push_back(8'h12);
    push_cyc(16'h4000, 1'b1, 8'h00);
    push_cyc(16'h4001, 1'b1, 8'h00);
    push_done(0, 1'b1, 16'h1234);
    do_accept(0, 1'b0, 1'b1, 16'h4000, 16'h0000);
    wait_done();

    // Spurious cyc_done while idle, then a byte read with valid dropped after ready.
    @(posedge clk); #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(negedge clk);
    check("spurious_idle", {63'd0, busy}, 64'd0);
    unit_delay = 2;
    rbytes.push_back(8'h5A);
    push_cyc(16'h00FF, 1'b1, 8'h00);
    push_done(0, 1'b1, 16'h005A);
    do_accept(0, 1'b0, 1'b0, 16'h00FF, 16'h0000);
    wait_done();

    // Reset while waiting on the first byte of a word read.
    unit_delay = 6;
    rbytes.push_back(8'h77);
    push_cyc(16'h5000, 1'b1, 8'h00);
    do_accept(0, 1'b0, 1'b1, 16'h5000, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid_outputs",
          {req0_ready, req0_done, req0_rdata, req1_ready, req1_done, req1_rdata,
           cyc_activate, cyc_addr, cyc_rd, cyc_wr, cyc_wdata, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 64'(dq.size()), 64'd0);
    rbytes.delete();
    unit_delay = 2;
    rbytes.push_back(8'h9A);
    rbytes.push_back(8'hBC);
    push_cyc(16'h6000, 1'b1, 8'h00);
    push_cyc(16'h6001, 1'b1, 8'h00);
    push_done(1, 1'b1, 16'hBC9A);
    do_accept(1, 1'b0, 1'b1, 16'h6000, 16'h0000);
    wait_done();

    // Contention: both requesters valid for four transactions.
`ifdef MEM_CYCLE_SEQ_RR_EN
    ids = '{0, 1, 0, 1};
`else
    ids = '{0, 0, 0, 0};
`endif
    unit_delay = 1;
    for (int i = 0; i < 4; i++) begin
      rbytes.push_back(8'hC1 + 8'(i));
      push_cyc(ids[i] == 0 ? 16'h0A00 : 16'h0B00, 1'b1, 8'h00);
      push_done(ids[i], 1'b1, 16'h00C1 + 16'(i));
    end
    @(posedge clk); #1;
    req0_wr = 1'b0; req0_word = 1'b0; req0_addr = 16'h0A00; req0_wdata = 16'h0000; req0_valid = 1'b1;
    req1_wr = 1'b0; req1_word = 1'b0; req1_addr = 16'h0B00; req1_wdata = 16'h0000; req1_valid = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) cnt++;
    end
    check("contention_accepts", 64'(cnt), 64'd4);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain("contention_drain");

    repeat (5) @(negedge clk);
    check("cyc_queue_empty", 64'(cq.size()), 64'd0);
    check("final_idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

endmodule
